// File: rtl/branch_ctrl.sv
// branch_ctrl: T3-T6 sub-sequencer for brzr/brnz/brpl/brmi; gates PCin on the condition flip-flop result.
// Optional taken/not-taken counters enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [1:0]        IR_C2,
    input  logic              BranchOut,
    output logic [1:0]        Cond,
    output logic              Gra,
    output logic              Rout,
    output logic              CONin,
    output logic              PCout,
    output logic              Yin,
    output logic              Cout,
    output logic              ADD,
    output logic              Zin,
    output logic              Zlowout,
    output logic              PCin,
    output logic              Busy,
    output logic              Done,
    output logic              Taken,
    output logic [STAT_W-1:0] TakenCnt,
    output logic [STAT_W-1:0] NotTakenCnt
);
    typedef enum logic [2:0] {IDLE, S_T3, S_T4, S_T5, S_T6} state_t;

    state_t     state_q, state_d;
    logic [1:0] cond_q;
    logic       taken_q, last_taken_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = Start ? S_T3 : IDLE;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {Gra, Rout, CONin} = {3{state_q == S_T3}};
        {PCout, Yin}       = {2{state_q == S_T4}};
        {Cout, ADD, Zin}   = {3{state_q == S_T5}};
        Zlowout            = state_q == S_T6;
        PCin               = (state_q == S_T6) && taken_q;
        Done               = state_q == S_T6;
        Busy               = state_q != IDLE;
    end

    // Decision is captured only at the T4->T5 edge and published at the end of T6.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cond_q       <= 2'b00;
            taken_q      <= 1'b0;
            last_taken_q <= 1'b0;
        end else begin
            if (state_q == IDLE && Start) cond_q <= IR_C2;
            if (state_q == S_T4) taken_q <= BranchOut;
            if (state_q == S_T6) last_taken_q <= taken_q;
        end
    end

    assign Cond  = cond_q;
    assign Taken = last_taken_q;

`ifdef BRANCH_CTRL_STATS_EN
    logic [STAT_W-1:0] taken_cnt_q, not_taken_cnt_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (state_q == S_T6) begin
            if (taken_q && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
            if (!taken_q && not_taken_cnt_q != '1) not_taken_cnt_q <= not_taken_cnt_q + 1'b1;
        end
    end

    assign TakenCnt    = taken_cnt_q;
    assign NotTakenCnt = not_taken_cnt_q;
`else
    assign TakenCnt    = '0;
    assign NotTakenCnt = '0;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed branch sequences checked every cycle against a step-count model.
module tb_branch_ctrl;
    localparam int W = 2;

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   IR_C2 = 2'b00;
    logic         BranchOut = 1'b0;
    logic [1:0]   Cond;
    logic         Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Busy, Done, Taken;
    logic [W-1:0] TakenCnt, NotTakenCnt;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    // model state: step = cycles since the accepted Start edge (-1 when idle)
    int       m_step = -1;
    bit [1:0] m_cond = 0;
    bit       m_dec = 0;
    bit       m_taken = 0;
    int       m_tc = 0, m_ntc = 0;
    int       conin_cnt = 0, pcin_cnt = 0, done_cnt = 0;

    branch_ctrl #(.STAT_W(W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .IR_C2(IR_C2), .BranchOut(BranchOut),
        .Cond(Cond), .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin),
        .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin), .Busy(Busy),
        .Done(Done), .Taken(Taken), .TakenCnt(TakenCnt), .NotTakenCnt(NotTakenCnt)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_step = -1; m_cond = 0; m_dec = 0; m_taken = 0; m_tc = 0; m_ntc = 0;
        end else if (m_step < 0) begin
            if (Start) begin m_step = 0; m_cond = IR_C2; end
        end else begin
            if (m_step == 1) m_dec = BranchOut;
            if (m_step == 3) begin
                m_taken = m_dec;
`ifdef BRANCH_CTRL_STATS_EN
                if (m_dec) m_tc = (m_tc < 3) ? m_tc + 1 : 3;
                else       m_ntc = (m_ntc < 3) ? m_ntc + 1 : 3;
`endif
            end
            m_step = (m_step == 3) ? -1 : m_step + 1;
        end
    end

    always @(negedge Clock) begin
        if (cmp_en) begin
            logic [14:0] exp_v, act_v;
            bit s0, s1, s2, s3;
            s0 = m_step == 0; s1 = m_step == 1; s2 = m_step == 2; s3 = m_step == 3;
            exp_v = {s0, s0, s0, s1, s1, s2, s2, s2, s3, s3 && m_dec, m_step >= 0, s3, m_taken, m_cond};
            act_v = {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Busy, Done, Taken, Cond};
            chk("outputs", {17'd0, act_v}, {17'd0, exp_v});
            chk("counters", {28'd0, TakenCnt, NotTakenCnt}, {28'd0, m_tc[1:0], m_ntc[1:0]});
            conin_cnt += CONin; pcin_cnt += PCin; done_cnt += Done;
            chk("one_bus_driver", Busy ? (Rout + PCout + Cout + Zlowout) : 0, Busy ? 1 : 0);
        end
    end

    // Walks one branch: BranchOut is the wanted value only in T4; optional ignored Start pulses in T4/T6.
    task automatic run_branch(input logic [1:0] c2, input logic bo, input bit poke);
        conin_cnt = 0; pcin_cnt = 0; done_cnt = 0;
        @(negedge Clock); Start = 1; IR_C2 = c2; BranchOut = ~bo;
        @(negedge Clock); Start = 0; IR_C2 = ~c2;
        @(negedge Clock); BranchOut = bo; Start = poke;
        @(negedge Clock); BranchOut = ~bo; Start = 0;
        @(negedge Clock); Start = poke;
        @(negedge Clock); Start = 0;
        chk("conin_pulses", conin_cnt, 1);
        chk("pcin_pulses", pcin_cnt, {31'd0, bo});
        chk("done_pulses", done_cnt, 1);
        chk("taken", {31'd0, Taken}, {31'd0, bo});
        chk("cond", {30'd0, Cond}, {30'd0, c2});
        chk("idle_after", {31'd0, Busy}, 0);
    endtask

    initial begin
        #1 Reset_n = 0;
        cmp_en = 1;
        repeat (2) @(negedge Clock);
        chk("reset_busy", {31'd0, Busy}, 0);
        chk("reset_strobes", {22'd0, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin}, 0);
        Reset_n = 1;
        @(negedge Clock);
        chk("idle_cond_taken", {29'd0, Cond, Taken}, 0);

        run_branch(2'b00, 1'b1, 0);
        run_branch(2'b11, 1'b0, 0);
        run_branch(2'b10, 1'b1, 1);
        run_branch(2'b01, 1'b0, 1);

        // abort mid-sequence in T5
        @(negedge Clock); Start = 1; IR_C2 = 2'b10;
        @(negedge Clock); Start = 0; BranchOut = 1;
        @(posedge Clock); @(posedge Clock);
        #2 Reset_n = 0;
        #1 chk("async_reset_now", {20'd0, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, Busy, Done}, 0);
        @(negedge Clock); chk("async_reset_cond", {30'd0, Cond}, 0);
        Reset_n = 1;
        run_branch(2'b01, 1'b1, 0);

        for (int i = 0; i < 4; i++) run_branch(2'(i), 1'b1, 0);
        run_branch(2'b11, 1'b0, 0);
`ifdef BRANCH_CTRL_STATS_EN
        chk("taken_cnt_sat", {30'd0, TakenCnt}, 3);
        chk("not_taken_cnt", {30'd0, NotTakenCnt}, 1);
`else
        chk("taken_cnt_off", {30'd0, TakenCnt}, 0);
        chk("not_taken_cnt_off", {30'd0, NotTakenCnt}, 0);
`endif
        @(negedge Clock);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
